// File: rtl/conv_seq_ctrl_8x8.sv
// conv_seq_ctrl_8x8: sequential 3x3 correlation over an 8x8 image of 2-bit
// pixels with a 2-bit filter. One shared multiply-accumulate performs one
// tap per clock. Each output pixel is streamed with its row/column index
// over a valid/ready handshake. A done pulse follows the last handshake.
// Optional build macro: STRIDE2_EN selects a window step of 2 in both
// dimensions, giving 9 outputs instead of 36.
module conv_seq_ctrl_8x8 #(
  parameter int IMG = 8,
  parameter int K   = 3,
  parameter int PW  = 2,
  parameter int OW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IMG*IMG*PW-1:0] img,
  input  logic [K*K*PW-1:0]     filt,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_data,
  output logic [2:0]            out_row,
  output logic [2:0]            out_col,
  output logic                  done
);

`ifdef STRIDE2_EN
  localparam int STEP_I = 2;
`else
  localparam int STEP_I = 1;
`endif
  localparam logic [2:0] STEP     = 3'(STEP_I);
  // Top-left coordinate of the final window in either dimension.
  localparam logic [2:0] LAST     = 3'(((IMG - K) / STEP_I) * STEP_I);
  localparam logic [3:0] TAP_LAST = 4'(K * K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IMG*IMG*PW-1:0] img_q;
  logic [K*K*PW-1:0]     filt_q;
  logic [2:0]            row, col;
  logic [3:0]            tap;
  logic [OW-1:0]         acc;

  logic [3:0]            tap_i, tap_j;
  int                    pix_idx;
  logic [PW-1:0]         pixel, weight;
  logic [2*PW-1:0]       prod;
  logic                  last_pos;

  // Current tap product: filter (i,j) times image (row+i, col+j), no flip.
  always_comb begin
    tap_i   = tap / 4'd3;
    tap_j   = tap % 4'd3;
    pix_idx = (int'(row) + int'(tap_i)) * IMG + int'(col) + int'(tap_j);
    pixel   = img_q[PW*pix_idx +: PW];
    weight  = filt_q[PW*int'(tap) +: PW];
    prod    = pixel * weight;
  end

  assign last_pos = (row == LAST) && (col == LAST);

  // Next-state logic for the sequencer.
  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (tap == TAP_LAST) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = last_pos ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: operand latch, window position, tap counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched operands are cleared too, so an aborted run leaves nothing behind.
      img_q  <= '0;
      filt_q <= '0;
      row    <= '0;
      col    <= '0;
      tap    <= '0;
      acc    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            img_q  <= img;
            filt_q <= filt;
            row    <= '0;
            col    <= '0;
            tap    <= '0;
            acc    <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + OW'(prod);
          if (tap != TAP_LAST) tap <= tap + 4'd1;
        end
        S_OUT: begin
          if (out_ready) begin
            acc <= '0;
            tap <= '0;
            if (!last_pos) begin
              if (col == LAST) begin
                col <= '0;
                row <= row + STEP;
              end else begin
                col <= col + STEP;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode directly from state; the accumulator is frozen in S_OUT.
  assign busy      = (state_q == S_MAC) || (state_q == S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign out_data  = out_valid ? acc : '0;
  assign out_row   = row;
  assign out_col   = col;

endmodule

// File: tb/tb_conv_seq_ctrl_8x8.sv
// Testbench for conv_seq_ctrl_8x8: table-driven uniform vectors, a center-tap
// pass-through, a 5-cycle back-pressure stall, ignored mid-run starts, random
// jobs against a direct-sum reference model, and a mid-run reset abort.
// Honors STRIDE2_EN the same way the design does.
module tb_conv_seq_ctrl_8x8;

`ifdef STRIDE2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int NWIN      = (8 - 3) / STEP + 1;
  localparam int NPOS      = NWIN * NWIN;
  localparam int STALL_IDX = (NPOS == 36) ? 15 : 4;   // (2,3) or (2,2)
  localparam int RST_IDX   = (NPOS == 36) ? 19 : 4;   // (3,1) or (2,2)

  logic         clk, rst_n, start, out_ready;
  logic [127:0] img_in;
  logic [17:0]  filt_in;
  logic         busy, out_valid, done;
  logic [7:0]   out_data;
  logic [2:0]   out_row, out_col;

  int n_pass  = 0;
  int n_total = 0;
  int pos_r[$];
  int pos_c[$];

  typedef struct {
    int p;    // every pixel value
    int w;    // every tap value
    int exp;  // expected result for every window
  } vec_t;
  vec_t vecs[5];

  conv_seq_ctrl_8x8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .img       (img_in),
    .filt      (filt_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  function automatic int pix(input logic [127:0] im, input int r, input int c);
    return int'(im[2*(8*r+c) +: 2]);
  endfunction

  // Direct 3x3 correlation sum, wrapped to the 8-bit output width.
  function automatic int ref_conv(input logic [127:0] im, input logic [17:0] fl,
                                  input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(fl[2*(3*i+j) +: 2]) * pix(im, r + i, c + j);
    return s % 256;
  endfunction

  function automatic logic [127:0] fill_img(input int p);
    logic [127:0] v = '0;
    for (int k = 0; k < 64; k++) v[2*k +: 2] = 2'(p);
    return v;
  endfunction

  function automatic logic [17:0] fill_filt(input int w);
    logic [17:0] v = '0;
    for (int k = 0; k < 9; k++) v[2*k +: 2] = 2'(w);
    return v;
  endfunction

  function automatic logic [127:0] rand_img();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [16:0] all_outs();
    return {busy, out_valid, done, out_data, out_row, out_col};
  endfunction

  // mode: 0 ready high, 1 random ready, 2 stall 5 cycles at STALL_IDX,
  //       3 ready high with start pulses and changing img/filt mid-run.
  // unif: >=0 fixed expected value, -2 center-tap pixel, -1 reference model.
  task automatic run_job(input logic [127:0] im, input logic [17:0] fl,
                         input int mode, input int unif);
    int idx, cyc, first, stall, dones, exp;
    bit busy_low, rdy;
    @(negedge clk);
    img_in = im; filt_in = fl; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);  // acceptance edge E0 has passed
    start = 1'b0;
    idx = 0; cyc = 0; first = -1; stall = 0; dones = 0; busy_low = 0;
    while (idx < NPOS && cyc < 5000) begin
      if (!busy) busy_low = 1;
      if (done) dones++;
      if (mode == 3) begin
        start   = (cyc % 7 == 2);
        img_in  = rand_img();
        filt_in = 18'($urandom);
      end
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (unif >= 0)       exp = unif;
        else if (unif == -2) exp = pix(im, pos_r[idx] + 1, pos_c[idx] + 1);
        else                 exp = ref_conv(im, fl, pos_r[idx], pos_c[idx]);
        check($sformatf("data[%0d]", idx), 32'(out_data), exp);
        check($sformatf("row[%0d]", idx), 32'(out_row), pos_r[idx]);
        check($sformatf("col[%0d]", idx), 32'(out_col), pos_c[idx]);
        if (mode == 2 && idx == STALL_IDX && stall < 5) begin
          rdy = 1'b0;
          stall++;
        end
      end
      out_ready = rdy;
      if (out_valid && rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("job_complete", 32'(idx), NPOS);
    check("first_valid_latency", 32'(first), 9);
    check("busy_held", 32'(busy_low), 0);
    check("no_early_done", 32'(dones), 0);
    if (mode == 0) check("last_handshake_edge", 32'(cyc), 10 * NPOS);
    if (mode == 2) check("stall_cycles", 32'(stall), 5);
    check("done_pulse", 32'({done, busy, out_valid}), 32'b100);
    @(negedge clk);
    out_ready = 1'b0;
    check("done_cleared", 32'({done, busy, out_valid}), 0);
  endtask

  initial begin
    int found;
    vecs[0] = '{p: 3, w: 3, exp: 81};
    vecs[1] = '{p: 1, w: 1, exp: 9};
    vecs[2] = '{p: 2, w: 0, exp: 0};
    vecs[3] = '{p: 2, w: 1, exp: 18};
    vecs[4] = '{p: 3, w: 2, exp: 54};
    for (int r = 0; r <= 5; r += STEP)
      for (int c = 0; c <= 5; c += STEP) begin
        pos_r.push_back(r);
        pos_c.push_back(c);
      end

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; img_in = '0; filt_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(all_outs()), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 32'(all_outs()), 0);

    // Center tap only: each output equals the pixel under the window center.
    run_job(rand_img(), 18'(1) << 8, 0, -2);

    for (int v = 0; v < 5; v++)
      run_job(fill_img(vecs[v].p), fill_filt(vecs[v].w), 0, vecs[v].exp);

    run_job(rand_img(), 18'($urandom), 2, -1);
    run_job(rand_img(), 18'($urandom), 3, -1);
    for (int n = 0; n < 3; n++)
      run_job(rand_img(), 18'($urandom), 1, -1);

    // Abort mid-MAC with reset, then a fresh job must start from (0,0).
    @(negedge clk);
    img_in = fill_img(3); filt_in = fill_filt(3); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 1000 && found == 0; t++) begin
      if (busy && !out_valid && int'(out_row) == pos_r[RST_IDX] &&
          int'(out_col) == pos_c[RST_IDX]) found = 1;
      else @(negedge clk);
    end
    check("reached_abort_position", 32'(found), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs_zero", 32'(all_outs()), 0);
    repeat (2) @(negedge clk);
    check("abort_held_zero", 32'(all_outs()), 0);
    rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("post_abort_idle", 32'(all_outs()), 0);
    run_job(rand_img(), 18'($urandom), 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
